alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Two-port arbiter that time-shares a single-cycle integer ALU between two requesters, for example the EX stage and a secondary address/branch-compare client. It uses valid/ready handshakes on the request and response sides, round-robin fairness and one registered result slot per requester. It sits beside the EX stage. The arithmetic core is combinational; all sequencing, buffering and backpressure live in this block.

## Interface
- WIDTH, 32, operand/result width
- CNT_W, 16, width of the conflict statistics counter

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational grant)
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- req0_op / req1_op  in  3  operation code
- rsp0_valid / rsp1_valid  out  1  result slot holds a result
- rsp0_ready / rsp1_ready  in  1  consumer takes the result this cycle
- rsp0_result / rsp1_result  out  WIDTH  registered result
- rsp0_zero / rsp1_zero  out  1  registered (result == 0)
- conflict_cnt  out  CNT_W  saturating count of cycles where both requests were valid

## Operation
- Op encoding:
  - 000 ADD: A+B, mod 2^WIDTH.
  - 001 SUB: A−B, two's complement.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLT: result = {0…, bit WIDTH−1 of (A−B)}. This is the raw sign bit of the difference, with no overflow correction.
  - 110 and 111: result 0.
- Slot i is "free" when rspi_valid==0, or when rspi_valid==1 and rspi_ready==1 in the same cycle (drain-and-refill).
- Requester i is "eligible" when reqi_valid==1 and slot i is free.
- Priority pointer `prio` (1 bit, internal) names the favoured requester.
- Grant rules, at most one grant per cycle:
  - Both eligible: grant `prio`.
  - Exactly one eligible: grant it. This is work-conserving, even if it is not favoured.
  - None eligible: no grant.
- reqi_ready = granti. It is combinational from valid, rsp state and prio, and never depends on the op or operands.
- On granti at a clock edge:
  - The selected operands are computed through the shared ALU.
  - The result is written to rspi_result, and rspi_zero is written.
  - rspi_valid is set to 1.
  - prio becomes the other requester (1−i).
- prio is unchanged on cycles without a grant.
- Slot drains without refill (rspi_valid & rspi_ready & ~granti): rspi_valid goes to 0. rspi_result and rspi_zero hold their last values.
- rspi_valid & ~rspi_ready: the slot holds all of its outputs stable. requester i is not granted.
- conflict_cnt increments on every cycle where req0_valid & req1_valid, independent of eligibility. It saturates at 2^CNT_W−1.
- Requester inputs must stay stable while valid is high and ready is low. The block does not check this.

## Timing
- Reset (asynchronous assert, synchronous-release domain):
  - rsp0_valid = rsp1_valid = 0.
  - rsp*_result = 0.
  - rsp*_zero = 0.
  - conflict_cnt = 0.
  - prio = 0 (requester 0 favoured).
  - req*_ready = 0 while rst is high.
- Reset mid-operation discards any buffered result. No response is produced for a request accepted in the reset-assertion cycle.
- Latency: a request accepted at edge N has rspi_valid=1 after edge N, visible in cycle N+1.
- Throughput:
  - One accepted request per cycle overall.
  - Per requester, one per cycle when its consumer holds rspi_ready=1 continuously.
- Fairness: with both requests continuously valid and both consumers always ready, grants alternate 0,1,0,1,…
- Maximum wait for an eligible requester is 1 cycle.
- Simultaneous events on the same slot in the same cycle:
  - Drain plus refill: valid stays 1 and the new result replaces the old.
  - Drain of slot 0 plus grant to slot 1 is legal.

## Test plan
- Reset, then req0 ADD a=0x7FFFFFFF b=1 → req0_ready=1 the same cycle; next cycle rsp0_valid=1, rsp0_result=0x80000000, rsp0_zero=0; prio=1.
- req0 and req1 held valid, both rsp_ready=1, ops SUB 5−5 and XOR 0xF0F0^0x0FF0 → grants alternate 0,1,0,…; rsp0_result=0 with rsp0_zero=1; rsp1_result=0x0000FF00; conflict_cnt counts every cycle.
- rsp1_ready held 0 with rsp1_valid=1, req1_valid=1, prio=1, req0_valid=1 → req1_ready=0, req0 is granted (work-conserving), rsp1_result stays stable; raising rsp1_ready grants req1 the same cycle (drain+refill) and rsp1_valid stays 1.
- Op sweep on requester 0: SLT a=0xFFFFFFFF b=1 → 1; SLT a=0x80000000 b=1 → 0 (sign of difference only); op 110 → 0; op 111 → 0; AND/OR with 0xAAAA5555 and 0x0F0F0F0F → 0x0A0A0505 and 0xAFAF5F5F.
- Hold both valid for 2^CNT_W+3 cycles (CNT_W=4 build) → conflict_cnt saturates at 15.
- Assert rst while rsp0_valid=1 and a grant is pending → all outputs return to reset values immediately, without waiting for a clock edge; after release, the first grant goes to requester 0.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two ALU clients and alu_share_arbiter.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both 1;
// valid must not depend on ready, and payload must hold while valid is 1 and ready is 0.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_op;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_result;
  logic             rsp0_zero;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_result;
  logic             rsp1_zero;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, input req0_ready,
    output req1_valid, req1_a, req1_b, req1_op, input req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero, output rsp0_ready,
    input  rsp1_valid, rsp1_result, rsp1_zero, output rsp1_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op, output req1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero, input rsp0_ready,
    output rsp1_valid, rsp1_result, rsp1_zero, input rsp1_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational integer ALU between two requesters,
// with one registered result slot per requester and a saturating conflict counter.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_share_arbiter_if.slave   bus,
  output logic [CNT_W-1:0]     conflict_cnt,
  output logic                 prio_dbg_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [WIDTH-1:0] rsp0_result_q, rsp0_result_d;
  logic [WIDTH-1:0] rsp1_result_q, rsp1_result_d;
  logic             rsp0_zero_q, rsp0_zero_d;
  logic             rsp1_zero_q, rsp1_zero_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             elig0, elig1;
  logic             grant0, grant1;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;

  function automatic logic [WIDTH-1:0] alu(input logic [2:0] op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] diff;
    diff = a - b;
    alu  = '0;
    case (op)
      3'b000:  alu = a + b;
      3'b001:  alu = diff;
      3'b010:  alu = a & b;
      3'b011:  alu = a | b;
      3'b100:  alu = a ^ b;
      // Raw sign of the difference; overflow is deliberately not corrected.
      3'b101:  alu = {{(WIDTH-1){1'b0}}, diff[WIDTH-1]};
      default: alu = '0;
    endcase
    return alu;
  endfunction

  // A slot that is draining this cycle can be refilled in the same cycle.
  assign elig0 = bus.req0_valid & (~rsp0_valid_q | bus.rsp0_ready);
  assign elig1 = bus.req1_valid & (~rsp1_valid_q | bus.rsp1_ready);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (elig0 && elig1) begin
        grant0 = ~prio_q;
        grant1 = prio_q;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  always_comb begin
    alu_op = bus.req0_op;
    alu_a  = bus.req0_a;
    alu_b  = bus.req0_b;
    if (grant1) begin
      alu_op = bus.req1_op;
      alu_a  = bus.req1_a;
      alu_b  = bus.req1_b;
    end
    alu_y = alu(alu_op, alu_a, alu_b);
  end

  always_comb begin
    rsp0_valid_d  = rsp0_valid_q & ~bus.rsp0_ready;
    rsp1_valid_d  = rsp1_valid_q & ~bus.rsp1_ready;
    rsp0_result_d = rsp0_result_q;
    rsp1_result_d = rsp1_result_q;
    rsp0_zero_d   = rsp0_zero_q;
    rsp1_zero_d   = rsp1_zero_q;
    prio_d        = prio_q;
    cnt_d         = cnt_q;
    if (grant0) begin
      rsp0_valid_d  = 1'b1;
      rsp0_result_d = alu_y;
      rsp0_zero_d   = (alu_y == '0);
      prio_d        = 1'b1;
    end
    if (grant1) begin
      rsp1_valid_d  = 1'b1;
      rsp1_result_d = alu_y;
      rsp1_zero_d   = (alu_y == '0);
      prio_d        = 1'b0;
    end
    if (bus.req0_valid && bus.req1_valid && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp1_result_q <= '0;
      rsp0_zero_q   <= 1'b0;
      rsp1_zero_q   <= 1'b0;
      prio_q        <= 1'b0;
      cnt_q         <= '0;
    end else begin
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp1_result_q <= rsp1_result_d;
      rsp0_zero_q   <= rsp0_zero_d;
      rsp1_zero_q   <= rsp1_zero_d;
      prio_q        <= prio_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.rsp0_valid  = rsp0_valid_q;
  assign bus.rsp1_valid  = rsp1_valid_q;
  assign bus.rsp0_result = rsp0_result_q;
  assign bus.rsp1_result = rsp1_result_q;
  assign bus.rsp0_zero   = rsp0_zero_q;
  assign bus.rsp1_zero   = rsp1_zero_q;
  assign conflict_cnt    = cnt_q;
  assign prio_dbg_o      = prio_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: op table on requester 0, then hand-written
// sequences for alternation, backpressure, counter saturation and async reset.
module tb_alu_share_arbiter;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] conflict_cnt;
  logic             prio_dbg;
  int               checks;
  int               errors;
  int               exp_cnt;
  int               exp_prio;

  alu_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_share_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .conflict_cnt (conflict_cnt),
    .prio_dbg_o   (prio_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_result;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive_req0(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req0_valid = v;
    bus.req0_op    = op;
    bus.req0_a     = a;
    bus.req0_b     = b;
  endtask

  task automatic drive_req1(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req1_valid = v;
    bus.req1_op    = op;
    bus.req1_a     = a;
    bus.req1_b     = b;
  endtask

  // Advance one clock; inputs are always driven and sampled 1 time unit after posedge.
  task automatic tick(input logic both_valid);
    @(posedge clk);
    #1;
    if (both_valid && exp_cnt < 15) exp_cnt++;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_cnt  = 0;
    exp_prio = 0;

    vecs[0]  = '{3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};
    vecs[1]  = '{3'b001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1};
    vecs[2]  = '{3'b010, 32'hAAAA_5555, 32'h0F0F_0F0F, 32'h0A0A_0505, 1'b0};
    vecs[3]  = '{3'b011, 32'hAAAA_5555, 32'h0F0F_0F0F, 32'hAFAF_5F5F, 1'b0};
    vecs[4]  = '{3'b100, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0};
    vecs[5]  = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
    vecs[6]  = '{3'b101, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[7]  = '{3'b110, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[8]  = '{3'b111, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[9]  = '{3'b001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
    vecs[10] = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};

    // Reset with requests already valid: nothing may be granted.
    rst = 1'b1;
    drive_req0(1'b1, 3'b000, 32'd1, 32'd1);
    drive_req1(1'b1, 3'b000, 32'd2, 32'd2);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
    chk("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    chk("rst_rsp0_result", bus.rsp0_result, 32'd0);
    chk("rst_rsp1_result", bus.rsp1_result, 32'd0);
    chk("rst_rsp0_zero", 32'(bus.rsp0_zero), 32'd0);
    chk("rst_cnt", 32'(conflict_cnt), 32'd0);
    chk("rst_prio", 32'(prio_dbg), 32'd0);
    rst = 1'b0;
    drive_req1(1'b0, 3'b000, 32'd0, 32'd0);

    // Op table on requester 0; every grant makes requester 1 favoured.
    for (int i = 0; i < 11; i++) begin
      drive_req0(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      #1;
      chk($sformatf("tab%0d_req0_ready", i), 32'(bus.req0_ready), 32'd1);
      tick(1'b0);
      chk($sformatf("tab%0d_rsp0_valid", i), 32'(bus.rsp0_valid), 32'd1);
      chk($sformatf("tab%0d_result", i), bus.rsp0_result, vecs[i].exp_result);
      chk($sformatf("tab%0d_zero", i), 32'(bus.rsp0_zero), 32'(vecs[i].exp_zero));
      chk($sformatf("tab%0d_prio", i), 32'(prio_dbg), 32'd1);
    end

    // Drain without refill: valid drops, data holds.
    drive_req0(1'b0, 3'b000, 32'd0, 32'd0);
    tick(1'b0);
    chk("drain_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    chk("drain_rsp0_result_hold", bus.rsp0_result, 32'd0);
    chk("drain_rsp0_zero_hold", 32'(bus.rsp0_zero), 32'd1);
    exp_prio = 1;

    // Both continuously valid, both consumers ready: strict alternation.
    drive_req0(1'b1, 3'b001, 32'd5, 32'd5);
    drive_req1(1'b1, 3'b100, 32'h0000_F0F0, 32'h0000_0FF0);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("alt%0d_req0_ready", c), 32'(bus.req0_ready), 32'(exp_prio == 0));
      chk($sformatf("alt%0d_req1_ready", c), 32'(bus.req1_ready), 32'(exp_prio == 1));
      tick(1'b1);
      chk($sformatf("alt%0d_rsp0_valid", c), 32'(bus.rsp0_valid), 32'(exp_prio == 0));
      chk($sformatf("alt%0d_rsp1_valid", c), 32'(bus.rsp1_valid), 32'(exp_prio == 1));
      if (exp_prio == 0) begin
        chk($sformatf("alt%0d_rsp0_result", c), bus.rsp0_result, 32'd0);
        chk($sformatf("alt%0d_rsp0_zero", c), 32'(bus.rsp0_zero), 32'd1);
      end else begin
        chk($sformatf("alt%0d_rsp1_result", c), bus.rsp1_result, 32'h0000_FF00);
        chk($sformatf("alt%0d_rsp1_zero", c), 32'(bus.rsp1_zero), 32'd0);
      end
      chk($sformatf("alt%0d_cnt", c), 32'(conflict_cnt), 32'(exp_cnt));
      exp_prio = 1 - exp_prio;
    end

    // Backpressure on slot 1: fill it, then hold rsp1_ready low.
    drive_req0(1'b0, 3'b000, 32'd0, 32'd0);
    drive_req1(1'b1, 3'b000, 32'd3, 32'd4);
    bus.rsp1_ready = 1'b0;
    #1;
    chk("bp_a_req1_ready", 32'(bus.req1_ready), 32'd1);
    tick(1'b0);
    chk("bp_a_rsp1_result", bus.rsp1_result, 32'd7);
    drive_req1(1'b0, 3'b000, 32'd0, 32'd0);
    drive_req0(1'b1, 3'b000, 32'd1, 32'd1);
    tick(1'b0);
    chk("bp_b_prio", 32'(prio_dbg), 32'd1);
    chk("bp_b_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
    drive_req0(1'b1, 3'b000, 32'd2, 32'd2);
    drive_req1(1'b1, 3'b011, 32'h0000_0100, 32'h0000_0001);
    #1;
    chk("bp_c_req1_ready", 32'(bus.req1_ready), 32'd0);
    chk("bp_c_req0_ready", 32'(bus.req0_ready), 32'd1);
    tick(1'b1);
    chk("bp_c_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
    chk("bp_c_rsp1_result", bus.rsp1_result, 32'd7);
    chk("bp_c_rsp0_result", bus.rsp0_result, 32'd4);
    chk("bp_c_prio", 32'(prio_dbg), 32'd1);
    bus.rsp1_ready = 1'b1;
    #1;
    chk("bp_d_req1_ready", 32'(bus.req1_ready), 32'd1);
    chk("bp_d_req0_ready", 32'(bus.req0_ready), 32'd0);
    tick(1'b1);
    chk("bp_d_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
    chk("bp_d_rsp1_result", bus.rsp1_result, 32'h0000_0101);
    chk("bp_d_prio", 32'(prio_dbg), 32'd0);
    chk("bp_d_cnt", 32'(conflict_cnt), 32'(exp_cnt));

    // Saturation: 2^CNT_W + 3 cycles with both requests valid.
    for (int c = 0; c < 19; c++) begin
      tick(1'b1);
      chk($sformatf("sat%0d_cnt", c), 32'(conflict_cnt), 32'(exp_cnt));
    end
    chk("sat_final_cnt", 32'(conflict_cnt), 32'd15);

    // Asynchronous reset with a buffered result and a grant pending.
    drive_req0(1'b0, 3'b000, 32'd0, 32'd0);
    drive_req1(1'b0, 3'b000, 32'd0, 32'd0);
    tick(1'b0);
    drive_req0(1'b1, 3'b000, 32'd5, 32'd6);
    bus.rsp0_ready = 1'b0;
    tick(1'b0);
    chk("ar_pre_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
    drive_req1(1'b1, 3'b000, 32'd8, 32'd8);
    #1;
    chk("ar_pre_req1_ready", 32'(bus.req1_ready), 32'd1);
    rst = 1'b1;
    exp_cnt = 0;
    #1;
    chk("ar_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    chk("ar_rsp0_result", bus.rsp0_result, 32'd0);
    chk("ar_rsp1_result", bus.rsp1_result, 32'd0);
    chk("ar_rsp0_zero", 32'(bus.rsp0_zero), 32'd0);
    chk("ar_cnt", 32'(conflict_cnt), 32'd0);
    chk("ar_prio", 32'(prio_dbg), 32'd0);
    chk("ar_req1_ready", 32'(bus.req1_ready), 32'd0);
    chk("ar_req0_ready", 32'(bus.req0_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.rsp0_ready = 1'b1;
    #1;
    chk("ar_post_req0_ready", 32'(bus.req0_ready), 32'd1);
    chk("ar_post_req1_ready", 32'(bus.req1_ready), 32'd0);
    tick(1'b1);
    chk("ar_post_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
    chk("ar_post_rsp0_result", bus.rsp0_result, 32'd11);
    chk("ar_post_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    chk("ar_post_cnt", 32'(conflict_cnt), 32'(exp_cnt));

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
